seq_detector_param: RTL
=======================

# seq_detector_param

Runtime-programmable serial sequence detector, the parametrised successor to the fixed 1101 Mealy detector. It accepts a bit stream qualified by `in_valid` and matches it against a loadable pattern of 1..MAX_LEN bits, in overlapping or non-overlapping mode. It flags each match combinationally in the same cycle (Mealy) and keeps a saturating match count. It sits on the serial bit path after the input synchroniser and feeds the event/interrupt logic.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits, minimum 2.
- `CNT_W`, 8: width of the match counter.
- `LW`, derived, $clog2(MAX_LEN+1): width of length fields. Not overridden.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in` carries a stream bit this cycle.
- `in` in 1: serial data bit.
- `cfg_load` in 1: one-cycle strobe that loads the configuration.
- `cfg_pattern` in MAX_LEN: new pattern; bits [cfg_len-1:0] are used; bit [len-1] is the first bit received.
- `cfg_len` in LW: new pattern length.
- `cfg_overlap` in 1: 1 = overlapping detection, 0 = non-overlapping.
- `out` out 1: Mealy match flag, combinational from the current state and `in`/`in_valid`.
- `match_count` out CNT_W: saturating count of matches.
- `cfg_err` out 1: registered one-cycle pulse on a rejected load.

## Operation
- State:
  - `hist`: MAX_LEN-1-bit shift register of past valid bits.
  - `fill`: LW-bit count of valid history bits, saturating at MAX_LEN-1.
  - `pat`, `len`, `ovl`: the active configuration.
  - `match_count`.
- Reset values:
  - `hist` = 0, `fill` = 0, `match_count` = 0, `cfg_err` = 0, `out` = 0.
  - `pat` = 'b1101 (zero-extended), `len` = 4, `ovl` = 1. This is the legacy 1101 overlapping behaviour.
- Match condition:
  - `out` = `in_valid` & !`cfg_load` & (`fill` >= `len`-1) & ({`hist`,`in`}[len-1:0] == `pat`[len-1:0]).
  - `out` is 0 in every other case.
- On a valid bit with no load:
  - `hist` <= {`hist`, `in`} truncated to MAX_LEN-1 bits.
  - `fill` <= min(`fill`+1, MAX_LEN-1).
- Overlap mode, on a match: the history shifts normally, so the suffix of one match can start the next.
- Non-overlap mode, on a match: `fill` <= 0 and `hist` <= 0. The next match needs `len` fresh bits.
- Match counter:
  - Increments when `out` = 1.
  - Holds at 2^CNT_W-1 once reached (saturates).
- `in_valid` = 0: no state changes, `out` = 0.
- `cfg_load` with 2 <= `cfg_len` <= MAX_LEN:
  - Latch `pat`, `len`, `ovl`.
  - Clear `hist`, `fill` and `match_count`.
  - Ignore `in` that cycle, even if `in_valid` = 1.
- `cfg_load` with `cfg_len` < 2 or `cfg_len` > MAX_LEN:
  - Keep the old configuration and history; `in` is still ignored that cycle.
  - Pulse `cfg_err` for one cycle, starting at the next edge.
- Asserting `rst` at any time, including mid-pattern, restores the reset values immediately (asynchronously).

## Timing
- `out` has zero latency: it is valid in the same cycle as the matching bit, before the clock edge.
- `match_count` reflects a match one cycle later (after the edge).
- A new configuration takes effect for the first valid bit in the cycle after `cfg_load`.
- Minimum cycles from load to first match = `len` valid bits.
- `cfg_err` is high for exactly one cycle after the rejected load edge.
- Back-to-back valid bits every cycle are supported; throughput is 1 bit/cycle.

## Structure
- Package `seq_det_pkg` holds:
  - Default constants `DEF_PATTERN` = 'b1101, `DEF_LEN` = 4, `DEF_OVERLAP` = 1.
  - A `MIN_LEN` = 2 constant.
- One sub-module, `sat_counter`:
  - Parameter: WIDTH.
  - Ports: clk, rst, clr, inc, count.
  - Used for `match_count`.
- Everything else is in the top module: history/fill register, masked comparator (mask built from `len`), config registers.

## Test plan
- Reset defaults, overlap mode: stream 1,1,0,1,1,0,1 → `out` = 1 on bits 4 and 7 only; `match_count` = 2.
- Non-overlap: load pattern 'b1101, len 4, `cfg_overlap` = 0; stream 1,1,0,1,1,0,1 → `out` on bit 4 only; `match_count` = 1.
- Length/pattern boundary, MAX_LEN=8:
  - Load 'b10110011, len 8; stream of exactly those 8 bits → `out` on bit 8.
  - Load len 2, pattern 'b11; stream 1,1,1 → matches on bits 2 and 3.
- Invalid load and valid gaps:
  - Load len 0 → `cfg_err` pulses once and the 1101 detection still works.
  - Interleave `in_valid` = 0 gaps inside 1,1,0,1 → one match, no `out` during gaps.
- Saturation, CNT_W=2: 5 matches → `match_count` goes 1, 2, 3, then stays 3. Then `cfg_load` → 0.
- Mid-pattern events:
  - Assert `rst` after 1,1,0 and release; then feed 1 → no match.
  - Assert `cfg_load` together with the final matching bit → `out` = 0 and history cleared.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and types for the programmable serial sequence detector.
// The defaults reproduce the legacy fixed 1101 overlapping detector, so a
// freshly reset block behaves exactly like the design it replaces.
// -----------------------------------------------------------------------------
package seq_det_pkg;

    // Power-on configuration: legacy 1101, overlapping.
    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    localparam int         DEF_LEN     = 4;
    localparam logic       DEF_OVERLAP = 1'b1;

    // Shortest pattern the detector accepts on a configuration load.
    localparam int         MIN_LEN     = 2;

    // Outcome of the configuration port in a given cycle.
    typedef enum logic [1:0] {
        CFG_NONE,
        CFG_ACCEPT,
        CFG_REJECT
    } cfg_action_e;

endpackage

// File: rtl/seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// seq_detector_param_if
// Bundles the stream, configuration and result signals of the detector.
//   master : drives in_valid/in and the cfg_* load port, observes results
//   slave  : the detector itself
// Signals:
//   in_valid, in             serial bit stream and its qualifier
//   cfg_load                 one-cycle configuration strobe
//   cfg_pattern/len/overlap  configuration presented with cfg_load
//   out                      combinational (Mealy) match flag
//   match_count              saturating match counter
//   cfg_err                  one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               in_valid;
    logic               in;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               out;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  out, match_count, cfg_err
    );

    modport slave (
        input  in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output out, match_count, cfg_err
    );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear, has priority over inc
//   inc      : count one event this cycle
//   count    : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next value: clear wins, otherwise step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Runtime-programmable serial sequence detector. Compares the most recent
// valid bits against a loadable pattern of MIN_LEN..MAX_LEN bits and raises
// a same-cycle (Mealy) match flag, in overlapping or non-overlapping mode.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of seq_detector_param_if (stream, config, results)
// The most recent bit is the live input itself, so only MAX_LEN-1 past bits
// are stored; the pattern's MSB (bit len-1) is the oldest bit of a match.
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int HW = MAX_LEN - 1;

    localparam logic [MAX_LEN-1:0] PAT_RESET = MAX_LEN'(DEF_PATTERN);
    localparam logic [LW-1:0]      LEN_RESET = LW'(DEF_LEN);

    logic [HW-1:0]      hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LW-1:0]      len_q,  len_d;
    logic               ovl_q,  ovl_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] len_mask;
    logic               cfg_len_ok;
    logic               pattern_hit;
    logic               history_full;
    logic               match;
    cfg_action_e        cfg_action;

    assign window = {hist_q, bus.in};

    // Only the low len bits of the window take part in the comparison.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign pattern_hit  = (((window ^ pat_q) & len_mask) == '0);
    assign history_full = (fill_q >= (len_q - LW'(1)));

    assign cfg_len_ok = (bus.cfg_len >= LW'(MIN_LEN)) &&
                        (bus.cfg_len <= LW'(MAX_LEN));

    always_comb begin
        cfg_action = CFG_NONE;
        if (bus.cfg_load) begin
            cfg_action = cfg_len_ok ? CFG_ACCEPT : CFG_REJECT;
        end
    end

    // A load cycle never matches: the stream bit is discarded that cycle.
    assign match = bus.in_valid && !bus.cfg_load && history_full && pattern_hit;

    // Next-state for history and configuration. A load (good or bad) takes
    // priority over the stream; a rejected load leaves everything untouched.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cfg_err_d = 1'b0;

        case (cfg_action)
            CFG_ACCEPT: begin
                pat_d  = bus.cfg_pattern;
                len_d  = bus.cfg_len;
                ovl_d  = bus.cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end
            CFG_REJECT: begin
                cfg_err_d = 1'b1;
            end
            default: begin
                if (bus.in_valid) begin
                    if (match && !ovl_q) begin
                        // Non-overlapping: the next match needs len fresh bits.
                        hist_d = '0;
                        fill_d = '0;
                    end else begin
                        hist_d = window[HW-1:0];
                        fill_d = (fill_q == LW'(HW)) ? fill_q : fill_q + LW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= PAT_RESET;
            len_q     <= LEN_RESET;
            ovl_q     <= DEF_OVERLAP;
            cfg_err_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cfg_action == CFG_ACCEPT),
        .inc   (match),
        .count (bus.match_count)
    );

    assign bus.out     = match;
    assign bus.cfg_err = cfg_err_q;

endmodule
